// File: rtl/qtz_feature_loader.sv
// Collects one sample of FEATURE_COUNT feature words from a valid/ready stream,
// presents it to the quantizer, pulses start_mapping and waits for mapping_done.
module qtz_feature_loader #(
  parameter int FEATURE_COUNT = 617,
  parameter int DATA_W        = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [DATA_W-1:0] input_values [0:FEATURE_COUNT-1],
  output logic              start_mapping,
  input  logic              mapping_done,
  output logic              busy,
  output logic              err_frame
);

  localparam int IDX_W = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] buf_r [0:FEATURE_COUNT-1];
  logic              err_r;
  logic              xfer_s;
  logic              final_s;

  // idx is always 0 in IDLE, so one write path serves both IDLE and LOAD
  assign in_ready      = en & nrst & ((state_r == IDLE) | (state_r == LOAD));
  assign xfer_s        = in_valid & in_ready;
  assign final_s       = (idx_r == LAST_IDX);
  assign start_mapping = en & (state_r == START);
  assign busy          = (state_r != IDLE);
  assign err_frame     = err_r;

  // Buffer drives the sample output with no extra latency
  always_comb begin
    for (int i = 0; i < FEATURE_COUNT; i++) begin
      input_values[i] = buf_r[i];
    end
  end

  // Frame sequencing, buffer writes and sticky length-error flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      err_r   <= 1'b0;
      for (int i = 0; i < FEATURE_COUNT; i++) begin
        buf_r[i] <= {DATA_W{1'b0}};
      end
    end else if (en) begin
      case (state_r)
        IDLE, LOAD: begin
          if (xfer_s) begin
            buf_r[idx_r] <= in_data;
            if (final_s || in_last) begin
              state_r <= START;
              if (final_s != in_last) begin
                err_r <= 1'b1;
              end else begin
                err_r <= err_r;
              end
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= LOAD;
            end
          end else begin
            state_r <= state_r;
          end
        end
        START: begin
          state_r <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mapping_done) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            for (int i = 0; i < FEATURE_COUNT; i++) begin
              buf_r[i] <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {IDX_W{1'b0}};
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule
